// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 1x3 router input port: buffers a whole payload, then
// streams header/payload/parity under busy. Optional ROUTER_PKT_TX_PARITY_INJ_EN adds inj_parity.
module router_pkt_tx #(
    parameter int MAX_LEN  = 63,
    parameter int IDLE_GAP = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_addr,
    input  logic [5:0] req_len,
    output logic       req_err,
    input  logic       pl_valid,
    input  logic [7:0] pl_data,
    output logic       pl_ready,
    input  logic       busy,
    input  logic       rx_err,
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    input  logic       inj_parity,
`endif
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_done,
    output logic [7:0] pkt_count,
    output logic [7:0] err_count
);

    localparam int GW = $clog2(IDLE_GAP + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;

    state_t          state, state_nx;
    logic [5:0]      len_q, idx, idx_nx, last_idx;
    logic [7:0]      header, parity, par_out;
    logic [7:0]      mem [MAX_LEN];
    logic [GW-1:0]   gap_cnt;
    logic            rx_q, rx_q2;
    logic            req_fire, req_bad, pl_fire;
    logic            req_ready_d, pl_ready_d, pkt_valid_d, req_err_d, tx_done_d;
    logic [7:0]      data_d;

    assign req_fire = req_valid && req_ready;
    assign req_bad  = (req_addr == 2'b11) || (req_len == 6'd0);
    assign pl_fire  = pl_valid && pl_ready;
    assign last_idx = len_q - 6'd1;

`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    logic inj_q;
    always_ff @(posedge clock) begin
        if (!resetn)
            inj_q <= 1'b0;
        else if (req_fire && !req_bad)
            inj_q <= inj_parity;
    end
    assign par_out = inj_q ? ~parity : parity;
`else
    assign par_out = parity;
`endif

    // State register plus the datapath registers that follow it
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            idx       <= '0;
            len_q     <= '0;
            header    <= '0;
            parity    <= '0;
            gap_cnt   <= '0;
            rx_q      <= 1'b0;
            rx_q2     <= 1'b0;
            req_ready <= 1'b0;
            pl_ready  <= 1'b0;
            pkt_valid <= 1'b0;
            data_out  <= 8'h00;
            req_err   <= 1'b0;
            tx_done   <= 1'b0;
            pkt_count <= 8'h00;
            err_count <= 8'h00;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            req_ready <= req_ready_d;
            pl_ready  <= pl_ready_d;
            pkt_valid <= pkt_valid_d;
            data_out  <= data_d;
            req_err   <= req_err_d;
            tx_done   <= tx_done_d;
            if (req_fire && !req_bad) begin
                len_q  <= req_len;
                header <= {req_len, req_addr};
                parity <= {req_len, req_addr};
            end else if (pl_fire) begin
                parity <= parity ^ pl_data;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
            if (tx_done_d)
                pkt_count <= pkt_count + 8'd1;
            rx_q  <= rx_err;
            rx_q2 <= rx_q;
            if (rx_q && !rx_q2 && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

    // Payload buffer carries no reset; stale bytes are never presented
    always_ff @(posedge clock) begin
        if (pl_fire)
            mem[idx] <= pl_data;
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                idx_nx = '0;
                if (req_fire && !req_bad) state_nx = LOAD;
            end
            LOAD: if (pl_fire) begin
                if (idx == last_idx) begin
                    state_nx = HEADER;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + 6'd1;
                end
            end
            HEADER: if (!busy) state_nx = PAYLOAD;
            PAYLOAD: if (!busy) begin
                if (idx == last_idx) begin
                    state_nx = PARITY;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + 6'd1;
                end
            end
            PARITY: if (!busy) state_nx = GAP;
            GAP: if (gap_cnt == GAP_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it
    always_comb begin
        req_ready_d = (state_nx == IDLE);
        pl_ready_d  = (state_nx == LOAD);
        pkt_valid_d = (state_nx == HEADER) || (state_nx == PAYLOAD);
        req_err_d   = req_fire && req_bad;
        tx_done_d   = (state == PARITY) && !busy;
        case (state_nx)
            HEADER:  data_d = header;
            PAYLOAD: data_d = mem[idx_nx];
            PARITY:  data_d = par_out;
            default: data_d = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: reset, basic, back-pressure, illegal requests,
// max length, counter wrap/saturation, mid-packet reset, optional parity injection.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       resetn;
    logic       req_valid, req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       req_err;
    logic       pl_valid, pl_ready;
    logic [7:0] pl_data;
    logic       busy, rx_err;
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
    logic       inj_parity;
`endif
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic [7:0] pkt_count, err_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] pay [64];

    router_pkt_tx dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_err(req_err),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
        .busy(busy), .rx_err(rx_err),
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
        .inj_parity(inj_parity),
`endif
        .pkt_valid(pkt_valid), .data_out(data_out), .tx_done(tx_done),
        .pkt_count(pkt_count), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [1:0] a, input logic [5:0] l, input logic inj);
        int g = 0;
        while (!req_ready && g < 100) begin
            step();
            g++;
        end
        chk("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
        inj_parity = inj;
`else
        if (inj) $display("note: parity injection not built in");
`endif
        step();
        req_valid = 1'b0;
    endtask

    // Feeds pay[0..len-1]; returns on the cycle HEADER is first presented
    task automatic load(input int len);
        int i = 0;
        int g = 0;
        pl_valid = 1'b1;
        while (i < len && g < 300) begin
            pl_data = pay[i];
            if (pl_ready) i++;
            step();
            g++;
        end
        pl_valid = 1'b0;
        chk("load_done", i, len);
    endtask

    task automatic check_tx(input logic [7:0] hdr, input int len, input logic [7:0] par,
                            input logic [7:0] cnt);
        chk("hdr_valid", pkt_valid, 1);
        chk("hdr_data", data_out, hdr);
        for (int i = 0; i < len; i++) begin
            step();
            chk("pl_valid_out", pkt_valid, 1);
            chk("pl_byte", data_out, pay[i]);
        end
        step();
        chk("par_valid", pkt_valid, 0);
        chk("par_data", data_out, par);
        chk("par_no_done", tx_done, 0);
        step();
        chk("tx_done", tx_done, 1);
        chk("pkt_count", pkt_count, cnt);
        chk("gap_data", data_out, 0);
        step();
        chk("tx_done_pulse", tx_done, 0);
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_addr = 2'b00; req_len = 6'd0;
        pl_valid = 1'b0; pl_data = 8'h00; busy = 1'b0; rx_err = 1'b0;
`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
        inj_parity = 1'b0;
`endif
        repeat (3) step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_pl_ready", pl_ready, 0);
        chk("rst_req_err", req_err, 0);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_err_count", err_count, 0);
        resetn = 1'b1;
        step();
        chk("post_rst_req_ready", req_ready, 1);

        // Basic packet
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        send_req(2'b01, 6'd3, 1'b0);
        chk("load_pl_ready", pl_ready, 1);
        chk("load_no_valid", pkt_valid, 0);
        load(3);
        check_tx(8'h0D, 3, 8'hDD, 8'd1);

        // Back-pressure on B2
        send_req(2'b01, 6'd3, 1'b0);
        load(3);
        chk("bp_hdr", data_out, 8'h0D);
        step();
        chk("bp_a1", data_out, 8'hA1);
        step();
        chk("bp_b2", data_out, 8'hB2);
        busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_data", data_out, 8'hB2);
            chk("bp_hold_valid", pkt_valid, 1);
        end
        busy = 1'b0;
        step();
        chk("bp_c3", data_out, 8'hC3);
        step();
        chk("bp_par", data_out, 8'hDD);
        chk("bp_par_valid", pkt_valid, 0);
        step();
        chk("bp_tx_done", tx_done, 1);
        chk("bp_count", pkt_count, 2);

        // Illegal requests
        send_req(2'b11, 6'd5, 1'b0);
        chk("ill_addr_err", req_err, 1);
        chk("ill_addr_ready", req_ready, 1);
        send_req(2'b00, 6'd0, 1'b0);
        chk("ill_len_err", req_err, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ill_err_clear", req_err, 0);
            chk("ill_no_valid", pkt_valid, 0);
            chk("ill_no_pl_ready", pl_ready, 0);
        end

        // Max length 63: header FC, parity FC ^ (00^..^3E) = C3
        for (int i = 0; i < 63; i++) pay[i] = 8'(i);
        send_req(2'b00, 6'd63, 1'b0);
        load(63);
        check_tx(8'hFC, 63, 8'hC3, 8'd3);

        // Short packets up to the 256th: count wraps to 0 with the tx_done pulse
        pay[0] = 8'h5A;
        for (int k = 4; k <= 256; k++) begin
            send_req(2'b10, 6'd1, 1'b0);
            load(1);
            check_tx(8'h06, 1, 8'h5C, 8'(k));
        end

        // Error counter
        for (int k = 0; k < 3; k++) begin
            rx_err = 1'b1; step();
            rx_err = 1'b0; step();
        end
        step(); step();
        chk("err_count_3", err_count, 3);
        for (int k = 0; k < 297; k++) begin
            rx_err = 1'b1; step();
            rx_err = 1'b0; step();
        end
        step(); step();
        chk("err_count_sat", err_count, 255);

        // Reset while HEADER is on the wire
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        send_req(2'b01, 6'd3, 1'b0);
        load(3);
        chk("mid_hdr_valid", pkt_valid, 1);
        resetn = 1'b0;
        step();
        chk("mid_rst_valid", pkt_valid, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_pkt_count", pkt_count, 0);
        chk("mid_rst_err_count", err_count, 0);
        resetn = 1'b1;
        step();
        chk("mid_rel_ready", req_ready, 1);
        chk("mid_rel_valid", pkt_valid, 0);

`ifdef ROUTER_PKT_TX_PARITY_INJ_EN
        send_req(2'b01, 6'd3, 1'b1);
        load(3);
        check_tx(8'h0D, 3, 8'h22, 8'd1);
        send_req(2'b01, 6'd3, 1'b0);
        load(3);
        check_tx(8'h0D, 3, 8'hDD, 8'd2);
`else
        send_req(2'b01, 6'd3, 1'b0);
        load(3);
        check_tx(8'h0D, 3, 8'hDD, 8'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the 1x3 router input port. It accepts a transfer request (destination address and payload length), buffers the whole payload internally, and then streams a complete packet into the router: header byte, payload bytes, then parity byte. It honours the router's `busy` back-pressure and counts completed packets and parity errors reported by the router. It sits between a host/test source and the router's `pkt_valid`/`data_in`/`busy`/`err` pins.

## Interface
- `MAX_LEN`, default 63: payload buffer depth in bytes; the length field is 6 bits, so the legal range is 1..63.
- `IDLE_GAP`, default 2: minimum number of idle cycles (`pkt_valid`=0) after each parity byte; legal range ≥1.

- `clock`  in  1  clock; all logic is rising-edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_addr`  in  2  destination port.
- `req_len`  in  6  payload length in bytes.
- `req_err`  out  1  one-cycle pulse when an illegal request is dropped.
- `pl_valid`  in  1  payload byte strobe.
- `pl_data`  in  8  payload byte.
- `pl_ready`  out  1  payload byte taken when `pl_valid && pl_ready`.
- `busy`  in  1  router back-pressure; a byte is consumed only on an edge where `busy`=0.
- `rx_err`  in  1  router error flag.
- `pkt_valid`  out  1  to router `pkt_valid`.
- `data_out`  out  8  to router `data_in`.
- `tx_done`  out  1  one-cycle pulse when the parity byte has been consumed.
- `pkt_count`  out  8  completed packets; wraps 255→0.
- `err_count`  out  8  rising edges of `rx_err`; saturates at 255.

## Operation
- **FSM states:** IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- **IDLE:**
  - `req_ready`=1.
  - On accept with `req_addr`==2'b11 or `req_len`==0: pulse `req_err`, stay in IDLE.
  - Otherwise: latch addr/len, set header = {len, addr}, set running parity = header, go to LOAD.
- **LOAD:**
  - `pl_ready`=1.
  - Each accepted byte is written to buffer[idx] and XORed into parity.
  - When the len-th byte is accepted, go to HEADER.
  - `pkt_valid` stays 0 throughout LOAD, so payload gaps can never truncate a packet.
- **HEADER:**
  - `pkt_valid`=1, `data_out`=header.
  - On an edge with `busy`=0, go to PAYLOAD and present buffer[0].
- **PAYLOAD:**
  - `pkt_valid`=1, `data_out`=buffer[idx].
  - Each edge with `busy`=0 advances idx.
  - After the last byte is consumed, go to PARITY.
- **PARITY:**
  - `pkt_valid`=0, `data_out`=parity.
  - On an edge with `busy`=0: pulse `tx_done`, increment `pkt_count`, go to GAP.
- **GAP:**
  - `pkt_valid`=0, `data_out`=0.
  - Hold for `IDLE_GAP` cycles, then go to IDLE. `busy` is ignored.
- **Error counter:** `err_count` increments on every 0→1 transition of registered `rx_err`, in any state.
- **Reset:**
  - Reset mid-packet returns the FSM to IDLE and discards the buffered packet.
  - The router is left with a truncated packet; recovering from that is the router's responsibility.

## Timing
- **Reset values:**
  - `req_ready`=0 during reset, 1 from the first cycle after reset.
  - `pl_ready`=0, `req_err`=0, `pkt_valid`=0, `data_out`=8'h00, `tx_done`=0, `pkt_count`=0, `err_count`=0.
- **Registered outputs:** all outputs are registered. HEADER is presented on the cycle after the final payload byte is accepted.
- **Minimum latency** (request accept to `tx_done`), with `busy`=0 and `pl_valid` always high: 1 + len (LOAD) + 1 (HEADER) + len (PAYLOAD) + 1 (PARITY) cycles.
- **Holding under `busy`:** while `busy`=1, `data_out` and `pkt_valid` are held stable. `busy` may rise in the same cycle a byte is first presented.
- **`pkt_count` wrap:** the 255→0 wrap and the `tx_done` pulse occur on the same edge.

## Configuration
- **`ROUTER_PKT_TX_PARITY_INJ_EN` defined:**
  - Adds input `inj_parity`  in  1, sampled at request accept.
  - If `inj_parity` was 1, the parity byte is transmitted as ~parity; the router is expected to raise `err`.
- **Not defined:** the port is absent and parity is always correct.

## Test plan
- **Reset:** hold `resetn`=0 for 3 cycles → all outputs 0; `req_ready`=1 on the cycle after release.
- **Basic packet:** addr=01, len=3, payload A1 B2 C3, `busy`=0.
  - `data_out` sequence 0D, A1, B2, C3 with `pkt_valid`=1.
  - Then DD with `pkt_valid`=0.
  - `tx_done` pulses once and `pkt_count`=1.
- **Back-pressure:** same packet, `busy`=1 for 3 cycles while B2 is presented → B2 and `pkt_valid`=1 held for 4 cycles, then C3; parity is still DD.
- **Illegal requests:** addr=11 len=5, then addr=00 len=0 → two `req_err` pulses, `pkt_valid` never rises, `pl_ready` stays 0.
- **Max length and counters:** len=63 with payload 00..3E.
  - Header FC, 63 payload bytes, correct parity.
  - Repeat to 256 packets: `pkt_count` wraps to 0.
  - Toggle `rx_err` 300 times: `err_count`=255.
- **Parity injection** (with `ROUTER_PKT_TX_PARITY_INJ_EN`): basic packet with `inj_parity`=1 → parity byte 22.
